// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32I instruction fetch stage with a credit-limited in-order fetch queue.
// if2dec_o packs the decode packet as {pc[31:2], inst32, instValid}.
module inst_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [29:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [29:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [62:0] if2dec_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [29:0]   fpc, rpc;
  logic [CW-1:0] inflight, drop, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [29:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];

  logic          grant, resp, push, pop, inst_valid;
  logic [CW-1:0] inflight_net;

  // inflight + count never exceeds DEPTH, so the CW-bit sum cannot wrap
  assign imem_req_o   = !rst && !redirect_i && ((inflight + count) < DEPTH_C);
  assign imem_addr_o  = fpc;
  assign grant        = imem_req_o && imem_gnt_i;
  assign resp         = imem_rvalid_i && (inflight != '0);
  assign push         = resp && (drop == '0) && !redirect_i;
  assign inst_valid   = !rst && (count != '0) && !redirect_i;
  assign pop          = inst_valid && !stall_i;
  assign inflight_net = inflight - CW'(resp);
  assign if2dec_o     = {q_pc[rd_ptr], q_inst[rd_ptr], inst_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_i) begin
      // everything still outstanding belongs to the wrong path
      fpc      <= redirect_pc_i;
      rpc      <= redirect_pc_i;
      inflight <= inflight_net;
      drop     <= inflight_net;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (grant) fpc <= fpc + 30'd1;
      inflight <= inflight_net + CW'(grant);
      if (resp && (drop != '0)) drop <= drop - CW'(1);
      if (push) begin
        rpc    <= rpc + 30'd1;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= rpc;
      q_inst[wr_ptr] <= imem_rdata_i;
    end
  end
endmodule
